sent_serial_msg_ctrl: RTL and testbench
=======================================

SENT_SERIAL_MSG_CTRL -- requirements
Module: sent_serial_msg_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; there SHALL be no other clock or reset.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- enable  in  1  start request, sampled in IDLE
- channel_format  in  1  0 short serial, 1 enhanced serial
- config_bit  in  1  enhanced only: 0 = 8-bit ID + 12-bit data; 1 = 4-bit ID + 16-bit data
- id_4bit  in  4  short / enhanced-config1 ID
- id_8bit  in  8  enhanced-config0 ID
- data_short  in  8  short-message data
- data_12bit  in  12  enhanced-config0 data
- data_16bit  in  16  enhanced-config1 data
- frame_ack  in  1  one-cycle pulse from the SENT transmitter: current frame consumed
- frame_valid  out  1  status bits valid for the current frame
- status_bit3  out  1  status nibble bit 3 for the current frame
- status_bit2  out  1  status nibble bit 2 for the current frame
- frame_idx  out  5  current frame index, 0-based
- busy  out  1  message in progress (CALC or SEND)
- msg_done  out  1  one-cycle pulse after the last frame is acked

Function
REQ-003 The state machine SHALL have four states: IDLE, CALC, SEND and DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-004 In IDLE, enable=1 at an edge SHALL latch all data and format inputs, clear the bit counter, seed the CRC and enter CALC. Later input changes SHALL NOT affect the message.
REQ-005 The message length SHALL be N frames: N=16 for short and N=18 for enhanced. The CRC length SHALL be M bits: M=12 for short and M=24 for enhanced.
REQ-006 Short message: msg16 = {id_4bit, data_short, crc4}. For frame k, status_bit3 SHALL be 1 when k==0 and 0 otherwise; status_bit2 SHALL be msg16[15-k].
REQ-007 Enhanced status_bit3 for k = 0..17 SHALL be: 1,1,1,1,1,1,0,C,F1[3:0] (MSB first),0,F2[3:0] (MSB first),0, where C = config_bit.
- config0: F1 = id_8bit[7:4], F2 = id_8bit[3:0].
- config1: F1 = id_4bit, F2 = data_16bit[15:12].
REQ-008 Enhanced status_bit2:
- k = 0..5 SHALL carry crc6[5:0], MSB first.
- k = 6..17 SHALL carry data_12bit[11:0] (config0) or data_16bit[11:0] (config1), MSB first.
REQ-009 The CRC SHALL be computed bit-serially in CALC, one input bit per clock, for exactly M cycles.
- Update rule: fb = crc[MSB] ^ din; crc = (crc << 1) ^ (fb ? P : 0).
- crc4: P = 4'b1101, seed 4'b0101. Input is {id_4bit, data_short}, MSB first.
- crc6: P = 6'b011001, seed 6'b010101. Input is, for k = 6..17, status_bit3[k] then status_bit2[k].
REQ-010 CALC SHALL end after the M-th bit. frame_valid SHALL be 1 after the M-th rising edge following the enable-sampling edge, with frame_idx=0.
REQ-011 In SEND, frame_valid=1 and the status bits for frame_idx SHALL be held stable until frame_ack.
- frame_ack=1 SHALL increment frame_idx at the next edge.
- frame_ack while frame_valid=0 SHALL be ignored.
REQ-012 frame_ack on frame N-1 SHALL move the block to DONE: frame_valid=0, busy=0, msg_done=1 for one cycle, frame_idx=0.
REQ-013 enable SHALL be ignored while busy=1. enable is accepted in IDLE only, including the cycle directly after DONE.
REQ-014 busy SHALL be 1 in CALC and SEND and 0 in IDLE and DONE.
REQ-015 Outside SEND, status_bit3 and status_bit2 SHALL be 0.

Reset
REQ-016 reset=1 at an edge SHALL force IDLE from any state, including mid-CALC and mid-SEND. reset SHALL take priority over enable and frame_ack.
REQ-017 The reset values of the outputs SHALL be: frame_valid=0, status_bit3=0, status_bit2=0, frame_idx=0, busy=0, msg_done=0.
REQ-018 An aborted message SHALL NOT produce msg_done.

Verification
REQ-019 Short message, id_4bit=4'hA, data_short=8'h55, enable pulse:
- frame_valid rises 12 edges after enable.
- status_bit2 over 16 acks = 16'hA553 (crc4=4'h3).
- status_bit3 = 1 on frame 0 only.
- msg_done pulses once.
REQ-020 Enhanced config0, id_8bit=8'h55, data_12bit=12'h123:
- frame_valid rises 24 edges after enable.
- bit3 sequence = 111111 0 0 0101 0 0101 0.
- bit2 frames 6..17 = 12'h123.
- bit2 frames 0..5 match a crc6 model per REQ-009.
REQ-021 Enhanced config1, id_4bit=4'hA, data_16bit=16'h1234:
- bit3 frames 7..11 = 1,1010.
- bit3 frames 13..16 = 0001.
- bit2 frames 6..17 = 12'h234.
REQ-022 Handshake stress:
- Hold frame_ack=0 for 50 cycles: frame_idx and status bits are unchanged.
- Pulse enable mid-SEND: it is ignored.
- Apply back-to-back acks: frame_idx advances once per ack.
REQ-023 Assert reset in CALC cycle 5 and again at SEND frame 9: all outputs are 0 on the next edge and no msg_done is produced. A fresh enable then completes a full message normally.
REQ-024 Pulse enable in the cycle after msg_done: the new message starts, and busy=1 on the next edge.

Source files
------------

// File: rtl/sent_serial_msg_ctrl.sv
// rtl/sent_serial_msg_ctrl.sv - SENT short/enhanced serial message sequencer with bit-serial CRC
//
// Builds one SENT serial message (16 frames short, 18 frames enhanced) and hands
// the per-frame status nibble bits 3/2 to the SENT transmitter.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   enable                start request, sampled in IDLE only
//   channel_format        0 short serial, 1 enhanced serial
//   config_bit            enhanced: 0 = 8-bit ID/12-bit data, 1 = 4-bit ID/16-bit data
//   id_4bit, id_8bit      message ID sources
//   data_short/12bit/16bit message data sources
//   frame_ack             transmitter consumed the current frame
//   frame_valid           status bits valid for frame_idx
//   status_bit3/2         status nibble bits for the current frame
//   frame_idx             current frame index, 0-based
//   busy                  message in progress (CALC or SEND)
//   msg_done              one-cycle pulse after the last frame is acked
module sent_serial_msg_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        channel_format,
  input  logic        config_bit,
  input  logic [3:0]  id_4bit,
  input  logic [7:0]  id_8bit,
  input  logic [7:0]  data_short,
  input  logic [11:0] data_12bit,
  input  logic [15:0] data_16bit,
  input  logic        frame_ack,
  output logic        frame_valid,
  output logic        status_bit3,
  output logic        status_bit2,
  output logic [4:0]  frame_idx,
  output logic        busy,
  output logic        msg_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]  state;
  logic        fmt_q;
  logic        cfg_q;
  logic [3:0]  id4_q;
  logic [7:0]  id8_q;
  logic [7:0]  dshort_q;
  logic [11:0] d12_q;
  logic [15:0] d16_q;
  logic [5:0]  crc_q;
  logic [4:0]  bit_cnt;
  logic [4:0]  frame_idx_q;

  logic [3:0]  f1;
  logic [3:0]  f2;
  logic [11:0] enh_data;
  logic [17:0] enh_b3;
  logic [17:0] enh_b2;
  logic [11:0] short_in;
  logic [15:0] short_msg;
  logic [23:0] enh_in;
  logic        crc_din;
  logic        crc_fb;
  logic [5:0]  crc_nxt;
  logic [4:0]  calc_last;
  logic [4:0]  frame_last;
  logic        in_send;

  // Frame bit vectors are MSB-first: bit (17-k) belongs to frame k.
  assign f1        = cfg_q ? id4_q : id8_q[7:4];
  assign f2        = cfg_q ? d16_q[15:12] : id8_q[3:0];
  assign enh_data  = cfg_q ? d16_q[11:0] : d12_q;
  assign enh_b3    = {6'b111111, 1'b0, cfg_q, f1, 1'b0, f2, 1'b0};
  assign enh_b2    = {crc_q, enh_data};
  assign short_in  = {id4_q, dshort_q};
  assign short_msg = {short_in, crc_q[3:0]};

  // crc6 input stream: frames 6..17, bit3 then bit2 of each. Built from the
  // data fields directly so the CRC never feeds its own input.
  always_comb begin
    enh_in = '0;
    for (int i = 0; i < 12; i++) begin
      enh_in[23 - 2*i] = enh_b3[11 - i];
      enh_in[22 - 2*i] = enh_data[11 - i];
    end
  end

  assign crc_din = fmt_q ? enh_in[5'd23 - bit_cnt] : short_in[4'd11 - bit_cnt[3:0]];

  always_comb begin
    crc_nxt = '0;
    if (fmt_q) begin
      crc_fb  = crc_q[5] ^ crc_din;
      crc_nxt = {crc_q[4:0], 1'b0} ^ (crc_fb ? 6'b011001 : 6'b000000);
    end else begin
      crc_fb  = crc_q[3] ^ crc_din;
      crc_nxt = {2'b00, ({crc_q[2:0], 1'b0} ^ (crc_fb ? 4'b1101 : 4'b0000))};
    end
  end

  assign calc_last  = fmt_q ? 5'd23 : 5'd11;
  assign frame_last = fmt_q ? 5'd17 : 5'd15;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      fmt_q       <= 1'b0;
      cfg_q       <= 1'b0;
      id4_q       <= '0;
      id8_q       <= '0;
      dshort_q    <= '0;
      d12_q       <= '0;
      d16_q       <= '0;
      crc_q       <= '0;
      bit_cnt     <= '0;
      frame_idx_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            fmt_q       <= channel_format;
            cfg_q       <= config_bit;
            id4_q       <= id_4bit;
            id8_q       <= id_8bit;
            dshort_q    <= data_short;
            d12_q       <= data_12bit;
            d16_q       <= data_16bit;
            crc_q       <= channel_format ? 6'b010101 : 6'b000101;
            bit_cnt     <= '0;
            frame_idx_q <= '0;
            state       <= ST_CALC;
          end
        end
        ST_CALC: begin
          crc_q   <= crc_nxt;
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == calc_last) begin
            frame_idx_q <= '0;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (frame_ack) begin
            if (frame_idx_q == frame_last) begin
              frame_idx_q <= '0;
              state       <= ST_DONE;
            end else begin
              frame_idx_q <= frame_idx_q + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_send     = (state == ST_SEND);
  assign frame_valid = in_send;
  assign busy        = (state == ST_CALC) || in_send;
  assign msg_done    = (state == ST_DONE);
  assign frame_idx   = frame_idx_q;
  assign status_bit3 = in_send && (fmt_q ? enh_b3[5'd17 - frame_idx_q] : (frame_idx_q == 5'd0));
  assign status_bit2 = in_send && (fmt_q ? enh_b2[5'd17 - frame_idx_q]
                                         : short_msg[4'd15 - frame_idx_q[3:0]]);

endmodule

// File: tb/tb_sent_serial_msg_ctrl.sv
// tb/tb_sent_serial_msg_ctrl.sv - directed self-checking bench for sent_serial_msg_ctrl
module tb_sent_serial_msg_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        channel_format;
  logic        config_bit;
  logic [3:0]  id_4bit;
  logic [7:0]  id_8bit;
  logic [7:0]  data_short;
  logic [11:0] data_12bit;
  logic [15:0] data_16bit;
  logic        frame_ack;
  logic        frame_valid;
  logic        status_bit3;
  logic        status_bit2;
  logic [4:0]  frame_idx;
  logic        busy;
  logic        msg_done;

  int total = 0;
  int bad   = 0;

  sent_serial_msg_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .channel_format(channel_format),
    .config_bit(config_bit), .id_4bit(id_4bit), .id_8bit(id_8bit),
    .data_short(data_short), .data_12bit(data_12bit), .data_16bit(data_16bit),
    .frame_ack(frame_ack), .frame_valid(frame_valid), .status_bit3(status_bit3),
    .status_bit2(status_bit2), .frame_idx(frame_idx), .busy(busy), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // crc6 reference: frames 6..17, bit3 then data bit, MSB first
  function automatic logic [5:0] crc6_model(input logic [17:0] b3, input logic [11:0] d);
    logic [5:0] c;
    logic       fb;
    logic [23:0] s;
    c = 6'b010101;
    for (int i = 0; i < 12; i++) begin
      s[23 - 2*i] = b3[11 - i];
      s[22 - 2*i] = d[11 - i];
    end
    for (int i = 23; i >= 0; i--) begin
      fb = c[5] ^ s[i];
      c  = {c[4:0], 1'b0} ^ (fb ? 6'b011001 : 6'b000000);
    end
    return c;
  endfunction

  task automatic set_in(input logic fmt, input logic cfg, input logic [3:0] i4,
                        input logic [7:0] i8, input logic [7:0] ds,
                        input logic [11:0] d12, input logic [15:0] d16);
    channel_format = fmt; config_bit = cfg; id_4bit = i4; id_8bit = i8;
    data_short = ds; data_12bit = d12; data_16bit = d16;
  endtask

  // Drives enable across one edge, then scrambles the inputs (must not matter).
  task automatic start_msg();
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    set_in(~channel_format, ~config_bit, ~id_4bit, ~id_8bit, ~data_short, ~data_12bit, ~data_16bit);
  endtask

  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (frame_valid) break;
    end
    chk("valid_latency", n, lat);
    chk("first_idx", frame_idx, 0);
  endtask

  task automatic do_frames(input int first, input int last, output logic [17:0] b3,
                           output logic [17:0] b2);
    b3 = '0; b2 = '0;
    for (int k = first; k <= last; k++) begin
      chk("frame_idx", frame_idx, k);
      b3 = {b3[16:0], status_bit3};
      b2 = {b2[16:0], status_bit2};
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
    end
    chk("done_pulse", msg_done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", frame_valid, 0);
    chk("done_idx", frame_idx, 0);
    chk("done_bits", {status_bit3, status_bit2}, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {frame_valid, status_bit3, status_bit2, frame_idx, busy, msg_done}, 0);
  endtask

  initial begin
    logic [17:0] b3, b2, e3;
    int dones;
    reset = 1'b1; enable = 1'b0; frame_ack = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    reset = 1'b0;

    // short message
    set_in(0, 0, 4'hA, 8'h00, 8'h55, 12'h0, 16'h0);
    start_msg();
    chk("calc_busy", busy, 1);
    wait_valid(12);
    do_frames(0, 15, b3, b2);
    chk("short_bit2", b2[15:0], 16'hA553);
    chk("short_bit3", b3[15:0], 16'h8000);
    @(posedge clk); #1;
    chk("done_one_cycle", msg_done, 0);

    // enhanced config0
    set_in(1, 0, 4'h0, 8'h55, 8'h00, 12'h123, 16'h0);
    start_msg();
    wait_valid(24);
    do_frames(0, 17, b3, b2);
    e3 = 18'b111111_0_0_0101_0_0101_0;
    chk("enh0_bit3", b3, e3);
    chk("enh0_data", b2[11:0], 12'h123);
    chk("enh0_crc6", b2[17:12], crc6_model(e3, 12'h123));
    @(posedge clk); #1;

    // enhanced config1
    set_in(1, 1, 4'hA, 8'h00, 8'h00, 12'h0, 16'h1234);
    start_msg();
    wait_valid(24);
    do_frames(0, 17, b3, b2);
    e3 = 18'b111111_0_1_1010_0_0001_0;
    chk("enh1_bit3_7_11", b3[10:6], 5'b11010);
    chk("enh1_bit3_13_16", b3[4:1], 4'b0001);
    chk("enh1_data", b2[11:0], 12'h234);
    chk("enh1_crc6", b2[17:12], crc6_model(e3, 12'h234));

    // enable in the cycle after DONE starts a new message
    set_in(0, 0, 4'hA, 8'h00, 8'h55, 12'h0, 16'h0);
    @(posedge clk); #1;
    chk("after_done_idle", {busy, msg_done}, 0);
    start_msg();
    chk("restart_busy", busy, 1);
    wait_valid(12);
    do_frames(0, 15, b3, b2);
    chk("restart_bit2", b2[15:0], 16'hA553);
    @(posedge clk); #1;

    // handshake stress on a short message
    set_in(0, 0, 4'hA, 8'h00, 8'h55, 12'h0, 16'h0);
    start_msg();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    wait_valid(11);
    for (int k = 0; k < 3; k++) begin
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
    end
    repeat (50) @(posedge clk);
    #1;
    chk("hold_idx", frame_idx, 3);
    chk("hold_bits", {status_bit3, status_bit2}, 2'b00);
    chk("hold_valid", frame_valid, 1);
    enable = 1'b1;
    set_in(1, 1, 4'h0, 8'h00, 8'h00, 12'h0, 16'h0);
    @(posedge clk); #1;
    enable = 1'b0;
    chk("enable_ignored", {busy, frame_valid, frame_idx}, {2'b11, 5'd3});
    frame_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    frame_ack = 1'b0;
    chk("b2b_idx", frame_idx, 6);
    do_frames(6, 15, b3, b2);
    chk("stress_tail_bit2", b2[9:0], 10'h153);
    @(posedge clk); #1;

    // reset mid-CALC
    set_in(0, 0, 4'hA, 8'h00, 8'h55, 12'h0, 16'h0);
    start_msg();
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("reset_calc");

    // reset mid-SEND at frame 9
    set_in(1, 0, 4'h0, 8'h55, 8'h00, 12'h123, 16'h0);
    start_msg();
    wait_valid(24);
    for (int k = 0; k < 9; k++) begin
      frame_ack = 1'b1;
      @(posedge clk); #1;
      frame_ack = 1'b0;
    end
    chk("pre_reset_idx", frame_idx, 9);
    reset = 1'b1;
    frame_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    frame_ack = 1'b0;
    chk_zero("reset_send");
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (msg_done) dones++;
    end
    chk("abort_no_done", dones, 0);

    // fresh message after aborts
    set_in(1, 0, 4'h0, 8'h55, 8'h00, 12'h123, 16'h0);
    start_msg();
    wait_valid(24);
    do_frames(0, 17, b3, b2);
    e3 = 18'b111111_0_0_0101_0_0101_0;
    chk("fresh_bit3", b3, e3);
    chk("fresh_bit2", b2, {crc6_model(e3, 12'h123), 12'h123});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
